// File: rtl/ori_hist_pkg.sv
// Shared definitions for the orientation histogram accumulator:
// the bin count, the bin index width and the control FSM state encoding.
package ori_hist_pkg;

  localparam int NUM_BINS = 32;
  localparam int BIN_W    = 5;

  typedef enum logic [1:0] {
    ACC  = 2'd0,  // accumulating window samples
    SCAN = 2'd1,  // sequential argmax over the bins
    OUT  = 2'd2,  // result presented downstream
    CLR  = 2'd3   // bins zeroed before the next window
  } state_t;

endpackage

// File: rtl/ori_hist_peak.sv
// Sequential argmax scanner. A one-cycle start pulse clears the running best
// and begins a 32-cycle walk over the bins. The caller supplies the bin value
// addressed by scan_idx. done is asserted combinationally during the cycle
// that compares the last bin, with res_dir/res_val already including that
// final compare.
module ori_hist_peak
  import ori_hist_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ACC_W-1:0] bin_val,
  output logic [BIN_W-1:0] scan_idx,
  output logic             done,
  output logic [BIN_W-1:0] res_dir,
  output logic [ACC_W-1:0] res_val
);

  logic             busy;
  logic [ACC_W-1:0] best_val;
  logic [BIN_W-1:0] best_idx;
  logic             greater;
  logic             last_bin;

  // Strictly-greater compare keeps the lowest index on a tie; result muxes.
  always_comb begin
    greater  = (bin_val > best_val);
    last_bin = (scan_idx == BIN_W'(NUM_BINS - 1));
    done     = busy && last_bin;
    res_dir  = greater ? scan_idx : best_idx;
    res_val  = greater ? bin_val  : best_val;
  end

  // Scan index walk and running best update.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      scan_idx <= '0;
      best_val <= '0;
      best_idx <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      scan_idx <= '0;
      best_val <= '0;
      best_idx <= '0;
    end else if (busy) begin
      if (greater) begin
        best_val <= bin_val;
        best_idx <= scan_idx;
      end
      if (last_bin) begin
        busy <= 1'b0;
      end else begin
        scan_idx <= scan_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ori_hist_acc.sv
// Orientation histogram accumulator. Accumulates WIN_PIX (direction,
// magnitude) samples into 32 bins at one sample per cycle, scans for the
// dominant bin, presents it through a valid/ready handshake, then clears
// the bins for the next window.
// Build option: ORI_HIST_SAT_EN makes bin adds saturate instead of wrap.
module ori_hist_acc
  import ori_hist_pkg::*;
#(
  parameter int MAG_W   = 8,
  parameter int ACC_W   = 16,
  parameter int WIN_PIX = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIN_W-1:0] in_dir,
  input  logic [MAG_W-1:0] in_mag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIN_W-1:0] out_dir,
  output logic [ACC_W-1:0] out_peak
);

  localparam int PIX_W = (WIN_PIX > 1) ? $clog2(WIN_PIX) : 1;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] hist [NUM_BINS];
  logic [PIX_W-1:0] pix_cnt;
  logic             accept;
  logic             last_pix;
  logic             scan_start;
  logic [ACC_W-1:0] bin_nxt;

  logic [BIN_W-1:0] scan_idx;
  logic             scan_done;
  logic [BIN_W-1:0] res_dir;
  logic [ACC_W-1:0] res_val;

  // Accept qualification and end-of-window detection.
  always_comb begin
    accept     = in_valid && in_ready;
    last_pix   = (pix_cnt == PIX_W'(WIN_PIX - 1));
    scan_start = accept && last_pix;
  end

  // Single-cycle read-modify-write value for the addressed bin.
`ifdef ORI_HIST_SAT_EN
  logic [ACC_W:0] bin_sum;
  always_comb begin
    bin_sum = {1'b0, hist[in_dir]} + (ACC_W + 1)'(in_mag);
    bin_nxt = bin_sum[ACC_W] ? {ACC_W{1'b1}} : bin_sum[ACC_W-1:0];
  end
`else
  always_comb begin
    bin_nxt = hist[in_dir] + ACC_W'(in_mag);
  end
`endif

  // Bin storage: cleared on reset and in CLR, updated on every accept.
  // NOTE: the bins are a flop array rather than a RAM, so reset and the
  // one-cycle CLR can zero all of them in parallel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BINS; i++) hist[i] <= '0;
    end else if (state == CLR) begin
      for (int i = 0; i < NUM_BINS; i++) hist[i] <= '0;
    end else if (accept) begin
      hist[in_dir] <= bin_nxt;
    end
  end

  // Sample counter over the current window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt <= '0;
    end else if (accept) begin
      pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
    end
  end

  // Argmax scanner reads bins through scan_idx; bins are frozen during SCAN.
  ori_hist_peak #(
    .ACC_W (ACC_W)
  ) u_peak (
    .clk      (clk),
    .rst      (rst),
    .start    (scan_start),
    .bin_val  (hist[scan_idx]),
    .scan_idx (scan_idx),
    .done     (scan_done),
    .res_dir  (res_dir),
    .res_val  (res_val)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACC;
    else     state <= state_nxt;
  end

  // FSM next-state logic.
  // NOTE: state_nxt defaults to the current state first so no path through
  // the case leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (scan_start) state_nxt = SCAN;
      SCAN:    if (scan_done)  state_nxt = OUT;
      OUT:     if (out_ready)  state_nxt = CLR;
      CLR:                     state_nxt = ACC;
      default:                 state_nxt = ACC;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready  = (state == ACC);
    out_valid = (state == OUT);
  end

  // Result registers: loaded with the final compare, held through OUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_dir  <= '0;
      out_peak <= '0;
    end else if (scan_done) begin
      out_dir  <= res_dir;
      out_peak <= res_val;
    end
  end

endmodule

// File: tb/tb_ori_hist_acc.sv
// Self-checking bench for ori_hist_acc. A default-parameter instance covers
// accumulation, ties, backpressure, gapped input and mid-window reset; a
// narrow-accumulator instance (ACC_W=12) covers bin overflow.
module tb_ori_hist_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_dir = '0;
  logic [7:0]  in_mag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_dir;
  logic [15:0] out_peak;

  logic        in_valid_b = 1'b0;
  logic        in_ready_b;
  logic [4:0]  in_dir_b = '0;
  logic [7:0]  in_mag_b = '0;
  logic        out_valid_b;
  logic        out_ready_b = 1'b0;
  logic [4:0]  out_dir_b;
  logic [11:0] out_peak_b;

  typedef struct packed {
    logic [4:0]  dir;
    logic [15:0] peak;
  } exp_t;

  exp_t sb[$];
  exp_t sb_b[$];

  int total = 0;
  int bad   = 0;

  ori_hist_acc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dir    (in_dir),
    .in_mag    (in_mag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dir   (out_dir),
    .out_peak  (out_peak)
  );

  ori_hist_acc #(
    .MAG_W   (8),
    .ACC_W   (12),
    .WIN_PIX (256)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .in_dir    (in_dir_b),
    .in_mag    (in_mag_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .out_dir   (out_dir_b),
    .out_peak  (out_peak_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one sample and hold it until the edge that accepts it.
  task automatic send(input logic [4:0] d, input logic [7:0] m);
    int waited;
    waited   = 0;
    in_dir   = d;
    in_mag   = m;
    in_valid = 1'b1;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready=%0b required=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Same as send, preceded by 0..2 idle cycles carrying junk on in_dir/in_mag.
  task automatic send_gap(input logic [4:0] d, input logic [7:0] m);
    int idle;
    idle = $urandom_range(0, 2);
    for (int i = 0; i < idle; i++) begin
      in_valid = 1'b0;
      in_dir   = 5'($urandom);
      in_mag   = 8'($urandom);
      @(posedge clk); #1;
    end
    send(d, m);
  endtask

  // Wait for the result, optionally check latency from the last accept edge,
  // and compare against the scoreboard head.
  task automatic collect(input string name, input bit chk_lat);
    int   lat;
    exp_t e;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s_valid_timeout: out_valid=%0b required=1", name, out_valid);
      return;
    end
    if (chk_lat) begin
      total++;
      if (lat !== 32) begin
        bad++;
        $display("FAIL %s_latency: edges=%0d required=32", name, lat);
      end
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s_scoreboard_empty: result with no expectation", name);
      return;
    end
    e = sb.pop_front();
    total++;
    if (out_dir !== e.dir) begin
      bad++;
      $display("FAIL %s_dir: got=%0d required=%0d", name, out_dir, e.dir);
    end
    total++;
    if (out_peak !== e.peak) begin
      bad++;
      $display("FAIL %s_peak: got=%0d required=%0d", name, out_peak, e.peak);
    end
  endtask

  // Output handshake, then CLR, then back to ACC.
  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s_clr: out_valid=%0b in_ready=%0b required 0/0",
               name, out_valid, in_ready);
    end
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready_return: in_ready=%0b required=1", name, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_dir !== 5'd0 || out_peak !== 16'd0) begin
      bad++;
      $display("FAIL reset_values: in_ready=%0b out_valid=%0b out_dir=%0d out_peak=%0d required 1/0/0/0",
               in_ready, out_valid, out_dir, out_peak);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_bin();
    sb.push_back('{dir: 5'd7, peak: 16'd2560});
    for (int i = 0; i < 256; i++) send(5'd7, 8'd10);
    collect("single_bin", 1'b1);
    handshake("single_bin");
  endtask

  task automatic test_tie();
    sb.push_back('{dir: 5'd3, peak: 16'd128});
    for (int i = 0; i < 128; i++) send(5'd3, 8'd1);
    for (int i = 0; i < 128; i++) send(5'd20, 8'd1);
    collect("tie", 1'b1);
    handshake("tie");
  endtask

  task automatic test_backpressure();
    sb.push_back('{dir: 5'd9, peak: 16'd512});
    for (int i = 0; i < 128; i++) begin
      send(5'd9, 8'd4);
      send(5'd2, 8'd1);
    end
    collect("bp_first", 1'b1);
    // Upstream keeps offering a sample while in_ready is low; it must be ignored.
    in_valid = 1'b1;
    in_dir   = 5'd1;
    in_mag   = 8'd200;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out_dir !== 5'd9 || out_peak !== 16'd512 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cycle %0d: out_valid=%0b out_dir=%0d out_peak=%0d in_ready=%0b required 1/9/512/0",
                 c, out_valid, out_dir, out_peak, in_ready);
      end
    end
    in_valid = 1'b0;
    handshake("bp_first");
    sb.push_back('{dir: 5'd1, peak: 16'd512});
    for (int i = 0; i < 256; i++) send(5'd1, 8'd2);
    collect("bp_next", 1'b1);
    handshake("bp_next");
  endtask

  task automatic test_gapped();
    sb.push_back('{dir: 5'd12, peak: 16'd768});
    for (int i = 0; i < 256; i++) send_gap(5'd12, 8'd3);
    collect("gapped", 1'b1);
    handshake("gapped");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 100; i++) send(5'd5, 8'd7);
    rst = 1'b1;
    #2;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_dir !== 5'd0 || out_peak !== 16'd0) begin
      bad++;
      $display("FAIL reset_mid_values: in_ready=%0b out_valid=%0b out_dir=%0d out_peak=%0d required 1/0/0/0",
               in_ready, out_valid, out_dir, out_peak);
    end
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    sb.push_back('{dir: 5'd5, peak: 16'd256});
    for (int i = 0; i < 256; i++) send(5'd5, 8'd1);
    collect("reset_mid", 1'b1);
    handshake("reset_mid");
  endtask

  task automatic test_overflow();
    int   acc;
    int   cyc;
    exp_t e;
`ifdef ORI_HIST_SAT_EN
    sb_b.push_back('{dir: 5'd31, peak: 16'd4095});
`else
    sb_b.push_back('{dir: 5'd31, peak: 16'd3840});
`endif
    acc = 0;
    cyc = 0;
    in_valid_b = 1'b1;
    in_dir_b   = 5'd31;
    in_mag_b   = 8'd255;
    while (acc < 256 && cyc < 1000) begin
      if (in_ready_b) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid_b = 1'b0;
    cyc = 0;
    while (!out_valid_b && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    e = sb_b.pop_front();
    total++;
    if (out_valid_b !== 1'b1 || out_dir_b !== e.dir || 16'(out_peak_b) !== e.peak) begin
      bad++;
      $display("FAIL overflow: out_valid=%0b out_dir=%0d out_peak=%0d required 1/%0d/%0d",
               out_valid_b, out_dir_b, out_peak_b, e.dir, e.peak);
    end
    out_ready_b = 1'b1;
    @(posedge clk); #1;
    out_ready_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_bin();
    test_tie();
    test_backpressure();
    test_gapped();
    test_reset_mid();
    test_overflow();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
